// File: rtl/warp_pkg.sv
// Shared definitions for the warp scheduling queue: descriptor field layout,
// arbitration mode encodings and the channel-index width helper.
package warp_pkg;

    localparam int unsigned WID_W     = 3;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned MASK_W    = 8;
    // Descriptor layout, MSB first: ready | warp id | PC | lane mask
    localparam int unsigned READY_BIT = WID_W + PC_W + MASK_W;

    localparam int unsigned ARB_STRICT = 0;
    localparam int unsigned ARB_RR     = 1;

    function automatic int unsigned log2_ch(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/warp_fifo_ch.sv
// Single-channel circular descriptor buffer with count-based full/empty and
// a combinational view of the head entry.
module warp_fifo_ch
    import warp_pkg::*;
#(
    parameter int unsigned DATA_W     = 44,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LOG2_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_W-1:0]     push_data,
    output logic [DATA_W-1:0]     head_data,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] head;
    logic [LOG2_DEPTH-1:0] tail;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == (LOG2_DEPTH+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/warp_sched_queue.sv
// Multi-channel warp descriptor queue: per-channel FIFOs, strict or round-robin
// read arbitration, empty-queue bypass and a registered read port.
module warp_sched_queue
    import warp_pkg::*;
#(
    parameter int unsigned DATA_W     = 44,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LOG2_DEPTH = 4,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned LOG2_CH    = log2_ch(NUM_CH),
    parameter int unsigned ARB_MODE   = ARB_STRICT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [NUM_CH-1:0]                wr_en,
    input  logic [NUM_CH*DATA_W-1:0]         wr_data,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH*(LOG2_DEPTH+1)-1:0] count,
    input  logic                             rd_en,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    output logic [LOG2_CH-1:0]               rd_ch,
    output logic                             ovf_err
);

    localparam int unsigned CW = LOG2_DEPTH + 1;

    logic [DATA_W-1:0]  head_data [NUM_CH];
    logic [NUM_CH-1:0]  push;
    logic [NUM_CH-1:0]  pop;
    logic [NUM_CH-1:0]  cand;
    logic               bypass;
    logic               grant_vld;
    logic [LOG2_CH-1:0] grant_ch;
    logic [LOG2_CH-1:0] rr_ptr;
    logic [LOG2_CH-1:0] base;
    logic [LOG2_CH-1:0] idx;
    logic [DATA_W-1:0]  grant_data;

    // With every queue empty the writers themselves become the candidates,
    // so the winning write is forwarded instead of stored.
    assign bypass = rd_en & (&empty) & (|wr_en);
    assign cand   = bypass ? wr_en : ~empty;
    assign base   = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = LOG2_CH'((32'(base) + i) % NUM_CH);
            if (!grant_vld && cand[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    assign grant_data = bypass ? wr_data[grant_ch*DATA_W +: DATA_W] : head_data[grant_ch];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = wr_en[c] & ~flush & ~(bypass & (grant_ch == LOG2_CH'(c)));
        assign pop[c]  = rd_en & ~flush & ~bypass & grant_vld & (grant_ch == LOG2_CH'(c));

        warp_fifo_ch #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push[c]),
            .pop       (pop[c]),
            .push_data (wr_data[c*DATA_W +: DATA_W]),
            .head_data (head_data[c]),
            .count     (count[c*CW +: CW]),
            .full      (full[c]),
            .empty     (empty[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ch    <= '0;
            rr_ptr   <= '0;
            ovf_err  <= 1'b0;
        end else if (flush) begin
            rd_valid <= 1'b0;
        end else begin
            if (|(wr_en & full)) ovf_err <= 1'b1;
            rd_valid <= rd_en & grant_vld;
            if (rd_en && grant_vld) begin
                rd_data <= grant_data;
                rd_ch   <= grant_ch;
                rr_ptr  <= LOG2_CH'((32'(grant_ch) + 1) % NUM_CH);
            end
        end
    end

endmodule

// File: tb/tb_warp_sched_queue.sv
// Bench for warp_sched_queue: strict and round-robin instances share stimulus
// and are compared against a queue-based reference model every cycle.
module tb_warp_sched_queue;

    localparam int unsigned DATA_W     = 44;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned LOG2_DEPTH = 4;
    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned LOG2_CH    = 1;
    localparam int unsigned CW         = LOG2_DEPTH + 1;

    typedef logic [DATA_W-1:0] data_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        flush;
    logic                        rd_en;
    logic [NUM_CH-1:0]           wr_en;
    logic [NUM_CH*DATA_W-1:0]    wr_data;

    logic [NUM_CH-1:0]           full_o   [2];
    logic [NUM_CH-1:0]           empty_o  [2];
    logic [NUM_CH*CW-1:0]        count_o  [2];
    logic                        rd_valid_o [2];
    data_t                       rd_data_o  [2];
    logic [LOG2_CH-1:0]          rd_ch_o    [2];
    logic                        ovf_o      [2];

    always #5 clk = ~clk;

    warp_sched_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH),
        .NUM_CH(NUM_CH), .LOG2_CH(LOG2_CH), .ARB_MODE(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o[0]), .empty(empty_o[0]), .count(count_o[0]), .rd_en(rd_en),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]), .rd_ch(rd_ch_o[0]), .ovf_err(ovf_o[0])
    );

    warp_sched_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH),
        .NUM_CH(NUM_CH), .LOG2_CH(LOG2_CH), .ARB_MODE(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o[1]), .empty(empty_o[1]), .count(count_o[1]), .rd_en(rd_en),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]), .rd_ch(rd_ch_o[1]), .ovf_err(ovf_o[1])
    );

    // Reference state: index 0 models strict priority, index 1 round-robin.
    data_t       mq [2][NUM_CH][$];
    logic        m_valid [2];
    data_t       m_data  [2];
    int unsigned m_ch    [2];
    int unsigned m_rr    [2];
    logic        m_ovf   [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NUM_CH; c++) mq[m][c].delete();
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_ch[m]    = 0;
            m_rr[m]    = 0;
            m_ovf[m]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int unsigned sz [NUM_CH];
            bit          all_empty;
            bit          byp;
            bit          got;
            int unsigned w;
            all_empty = 1'b1;
            got       = 1'b0;
            w         = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                sz[c] = mq[m][c].size();
                if (sz[c] != 0) all_empty = 1'b0;
            end
            if (flush) begin
                for (int c = 0; c < NUM_CH; c++) mq[m][c].delete();
                m_valid[m] = 1'b0;
                continue;
            end
            byp = rd_en && all_empty && (wr_en != '0);
            if (rd_en) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    int unsigned c;
                    c = ((m == 1 ? m_rr[m] : 0) + k) % NUM_CH;
                    if (!got && (byp ? wr_en[c] : (sz[c] != 0))) begin
                        got = 1'b1;
                        w   = c;
                    end
                end
            end
            m_valid[m] = got;
            if (got) begin
                m_ch[m]   = w;
                m_rr[m]   = (w + 1) % NUM_CH;
                m_data[m] = byp ? wr_data[w*DATA_W +: DATA_W] : mq[m][w].pop_front();
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en[c] && !(byp && c == w)) begin
                    if (sz[c] == DEPTH) m_ovf[m] = 1'b1;
                    else mq[m][c].push_back(wr_data[c*DATA_W +: DATA_W]);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rd_valid[%0d]", m), 64'(rd_valid_o[m]), 64'(m_valid[m]));
            chk($sformatf("rd_data[%0d]", m), 64'(rd_data_o[m]), 64'(m_data[m]));
            chk($sformatf("rd_ch[%0d]", m), 64'(rd_ch_o[m]), 64'(m_ch[m]));
            chk($sformatf("ovf_err[%0d]", m), 64'(ovf_o[m]), 64'(m_ovf[m]));
            for (int c = 0; c < NUM_CH; c++) begin
                int unsigned n;
                n = mq[m][c].size();
                chk($sformatf("count[%0d][%0d]", m, c), 64'(count_o[m][c*CW +: CW]), 64'(n));
                chk($sformatf("full[%0d][%0d]", m, c), 64'(full_o[m][c]), 64'(n == DEPTH));
                chk($sformatf("empty[%0d][%0d]", m, c), 64'(empty_o[m][c]), 64'(n == 0));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [1:0] we, input data_t d0, input data_t d1,
                         input logic rd, input logic fl);
        wr_en   = we;
        wr_data = {d1, d0};
        rd_en   = rd;
        flush   = fl;
        cycle();
    endtask

    function automatic data_t rnd_data();
        return DATA_W'({$urandom(), $urandom()});
    endfunction

    task automatic async_reset();
        @(posedge clk);
        #3;
        wr_en = '0; rd_en = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        data_t a;
        rst_n = 1'b0; flush = 1'b0; rd_en = 1'b0; wr_en = '0; wr_data = '0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        a = 44'h0AA00000001;
        drive(2'b10, '0, a, 1'b0, 1'b0);
        chk("empty_after_write", 64'(empty_o[0]), 64'(2'b01));

        // Two entries per channel, then five reads
        drive(2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
        drive(2'b01, rnd_data(), '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(2'b00, '0, '0, 1'b1, 1'b0);

        // Three entries per channel, six reads
        for (int i = 0; i < 3; i++) drive(2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(2'b00, '0, '0, 1'b1, 1'b0);

        // Fill ch0 past capacity, drain, then exercise pointer wrap
        for (int i = 0; i < DEPTH + 1; i++) drive(2'b01, rnd_data(), '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(2'b00, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(2'b01, rnd_data(), '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(2'b01, rnd_data(), '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(2'b00, '0, '0, 1'b1, 1'b0);

        // Bypass from empty with both channels writing
        drive(2'b11, 44'h00D0D0D0D00, 44'h00D1D1D1D11, 1'b1, 1'b0);
        drive(2'b00, '0, '0, 1'b1, 1'b0);

        // Flush with partial contents, then asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) drive(2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
        drive(2'b11, rnd_data(), rnd_data(), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            drive(2'($urandom_range(0, 3)), rnd_data(), rnd_data(),
                  1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
